// File: rtl/lda_pkg.sv
// Shared types and width helpers for the line-drawing engine.
package lda_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSteep,
        StOrder,
        StInit,
        StDraw,
        StDone
    } lda_state_e;

    function automatic int unsigned coord_width(input int unsigned xw, input int unsigned yw);
        return (xw > yw) ? xw : yw;
    endfunction

    // Two extra bits keep err - dy and err + dx in range for any endpoints.
    function automatic int unsigned err_width(input int unsigned xw, input int unsigned yw);
        return coord_width(xw, yw) + 2;
    endfunction

endpackage

// File: rtl/lda_engine_if.sv
// Command and pixel channels of the line-drawing engine.
interface lda_engine_if #(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8,
    parameter int unsigned CW = 3
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [XW-1:0] i_x0;
    logic [XW-1:0] i_x1;
    logic [YW-1:0] i_y0;
    logic [YW-1:0] i_y1;
    logic [CW-1:0] i_color;
    logic          i_abort;
    logic          o_pix_valid;
    logic          i_pix_ready;
    logic [XW-1:0] o_pix_x;
    logic [YW-1:0] o_pix_y;
    logic [CW-1:0] o_pix_color;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_cmd_valid, i_x0, i_x1, i_y0, i_y1, i_color, i_abort, i_pix_ready,
        input  o_cmd_ready, o_pix_valid, o_pix_x, o_pix_y, o_pix_color, o_busy, o_done
    );

    modport slave (
        input  i_cmd_valid, i_x0, i_x1, i_y0, i_y1, i_color, i_abort, i_pix_ready,
        output o_cmd_ready, o_pix_valid, o_pix_x, o_pix_y, o_pix_color, o_busy, o_done
    );
endinterface

// File: rtl/lda_step.sv
// Bresenham datapath: endpoint swap, ordering, delta setup and error stepping.
module lda_step
    import lda_pkg::*;
#(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [XW-1:0] i_x0,
    input  logic [XW-1:0] i_x1,
    input  logic [YW-1:0] i_y0,
    input  logic [YW-1:0] i_y1,
    input  logic          i_steep_en,
    input  logic          i_order_en,
    input  logic          i_init_en,
    input  logic          i_step_en,
    output logic [XW-1:0] o_pix_x,
    output logic [YW-1:0] o_pix_y,
    output logic          o_last
);
    localparam int unsigned CoordW = coord_width(XW, YW);
    localparam int unsigned ErrW   = err_width(XW, YW);

    logic [CoordW-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [CoordW-1:0] x_q, y_q, dx_q, dy_q;
    logic signed [ErrW-1:0] err_q;
    logic steep_q, yneg_q;

    logic [CoordW-1:0] adx, ady, dx_init;
    logic steep_now;
    logic signed [ErrW-1:0] err_sub, err_add;

    always_comb begin
        adx       = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady       = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        steep_now = ady > adx;
        dx_init   = x1_q - x0_q;
        err_sub   = err_q - $signed({2'b00, dy_q});
        err_add   = err_sub + $signed({2'b00, dx_q});
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            steep_q <= 1'b0;
            yneg_q  <= 1'b0;
        end else if (i_load) begin
            x0_q    <= CoordW'(i_x0);
            x1_q    <= CoordW'(i_x1);
            y0_q    <= CoordW'(i_y0);
            y1_q    <= CoordW'(i_y1);
            steep_q <= 1'b0;
        end else if (i_steep_en) begin
            steep_q <= steep_now;
            if (steep_now) begin
                x0_q <= y0_q;
                y0_q <= x0_q;
                x1_q <= y1_q;
                y1_q <= x1_q;
            end
        end else if (i_order_en) begin
            // Walk always runs with increasing x, so the endpoints may be reversed.
            if (x0_q > x1_q) begin
                x0_q <= x1_q;
                x1_q <= x0_q;
                y0_q <= y1_q;
                y1_q <= y0_q;
            end
        end else if (i_init_en) begin
            dx_q   <= dx_init;
            dy_q   <= ady;
            yneg_q <= !(y0_q < y1_q);
            err_q  <= $signed({2'b00, dx_init >> 1});
            x_q    <= x0_q;
            y_q    <= y0_q;
        end else if (i_step_en) begin
            x_q <= x_q + CoordW'(1);
            if (err_sub[ErrW-1]) begin
                y_q   <= yneg_q ? (y_q - CoordW'(1)) : (y_q + CoordW'(1));
                err_q <= err_add;
            end else begin
                err_q <= err_sub;
            end
        end
    end

    assign o_pix_x = steep_q ? y_q[XW-1:0] : x_q[XW-1:0];
    assign o_pix_y = steep_q ? x_q[YW-1:0] : y_q[YW-1:0];
    assign o_last  = (x_q == x1_q);

endmodule

// File: rtl/lda_engine.sv
// Line-drawing engine: command/abort FSM around the lda_step datapath.
module lda_engine
    import lda_pkg::*;
#(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8,
    parameter int unsigned CW = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    lda_engine_if.slave  bus
);
    lda_state_e state_q, state_d;
    logic [CW-1:0] color_q;
    logic accept, pix_hs, last;
    logic steep_en, order_en, init_en, step_en;

    assign accept = bus.i_cmd_valid && (state_q == StIdle);
    assign pix_hs = (state_q == StDraw) && bus.i_pix_ready;

    always_comb begin
        state_d  = state_q;
        steep_en = 1'b0;
        order_en = 1'b0;
        init_en  = 1'b0;
        step_en  = 1'b0;
        case (state_q)
            StIdle:  if (accept) state_d = StSteep;
            StSteep: begin
                steep_en = 1'b1;
                state_d  = StOrder;
            end
            StOrder: begin
                order_en = 1'b1;
                state_d  = StInit;
            end
            StInit: begin
                init_en = 1'b1;
                state_d = StDraw;
            end
            StDraw: begin
                if (pix_hs) begin
                    if (last) state_d = StDone;
                    else      step_en = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort wins over any handshake and freezes the datapath.
        if (state_q != StIdle && bus.i_abort) begin
            state_d  = StIdle;
            steep_en = 1'b0;
            order_en = 1'b0;
            init_en  = 1'b0;
            step_en  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) color_q <= bus.i_color;
        end
    end

    lda_step #(
        .XW (XW),
        .YW (YW)
    ) u_step (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (accept),
        .i_x0       (bus.i_x0),
        .i_x1       (bus.i_x1),
        .i_y0       (bus.i_y0),
        .i_y1       (bus.i_y1),
        .i_steep_en (steep_en),
        .i_order_en (order_en),
        .i_init_en  (init_en),
        .i_step_en  (step_en),
        .o_pix_x    (bus.o_pix_x),
        .o_pix_y    (bus.o_pix_y),
        .o_last     (last)
    );

    assign bus.o_cmd_ready = (state_q == StIdle);
    assign bus.o_pix_valid = (state_q == StDraw);
    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_done      = (state_q == StDone);
    assign bus.o_pix_color = color_q;

endmodule

// File: tb/tb_lda_engine.sv
// Scoreboard bench for lda_engine: directed lines, monitor pops expected pixels on handshake.
module tb_lda_engine;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lda_engine_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

    lda_engine #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int done_pending = 0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs = -10;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic expect_pix(input int x, input int y, input int c);
        pix_t p;
        p.x = x;
        p.y = y;
        p.c = c;
        exp_q.push_back(p);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        pix_t h;
        if (!rst) begin
            cyc++;
            if (bus.o_pix_valid && exp_q.size() != 0) begin
                h = exp_q[0];
                if (bus.i_pix_ready && !bus.i_abort) void'(exp_q.pop_front());
                else h = exp_q[0];
                check(bus.i_pix_ready ? "pix_x" : "stall_pix_x", int'(bus.o_pix_x), h.x);
                check(bus.i_pix_ready ? "pix_y" : "stall_pix_y", int'(bus.o_pix_y), h.y);
                check(bus.i_pix_ready ? "pix_c" : "stall_pix_c", int'(bus.o_pix_color), h.c);
                if (bus.i_pix_ready && !bus.i_abort) last_hs = cyc;
            end else if (bus.o_pix_valid && bus.i_pix_ready && !bus.i_abort) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.o_pix_x,
                         bus.o_pix_y);
            end
            if (bus.o_done) begin
                if (done_pending == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    done_pending--;
                    check("done_after_last_pix", cyc - last_hs, 1);
                    check("pix_left_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    task automatic send(input int x0, input int y0, input int x1, input int y1, input int c,
                        input bit junk);
        int k;
        k = 0;
        while (bus.o_cmd_ready !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("cmd_ready_before_send", int'(bus.o_cmd_ready), 1);
        bus.i_x0 = XW'(x0);
        bus.i_y0 = YW'(y0);
        bus.i_x1 = XW'(x1);
        bus.i_y1 = YW'(y1);
        bus.i_color = CW'(c);
        bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        while (bus.o_pix_valid !== 1'b1 && k < 20) begin
            // Offer a different command while busy; it must be ignored.
            if (junk && k < 2) begin
                bus.i_x0 = XW'(100);
                bus.i_y1 = YW'(200);
                bus.i_cmd_valid = 1'b1;
            end else begin
                bus.i_cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.i_cmd_valid = 1'b0;
        check("first_pix_latency", k, 3);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || done_pending != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, int'(exp_q.size() == 0 && done_pending == 0), 1);
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_x0 = '0;
        bus.i_x1 = '0;
        bus.i_y0 = '0;
        bus.i_y1 = '0;
        bus.i_color = '0;
        bus.i_abort = 1'b0;
        bus.i_pix_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", int'(bus.o_cmd_ready), 1);
        check("rst_pix_valid", int'(bus.o_pix_valid), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_pix_x", int'(bus.o_pix_x), 0);
        check("rst_pix_y", int'(bus.o_pix_y), 0);
        check("rst_pix_c", int'(bus.o_pix_color), 0);
        rst = 1'b0;

        // Horizontal line with junk commands offered while busy.
        for (int i = 0; i < 5; i++) expect_pix(i, 0, 5);
        done_pending++;
        send(0, 0, 4, 0, 5, 1'b1);
        check("busy_in_draw", int'(bus.o_busy), 1);
        wait_done("horizontal_line");

        // Steep line.
        expect_pix(1, 1, 2);
        expect_pix(1, 2, 2);
        expect_pix(2, 3, 2);
        expect_pix(2, 4, 2);
        expect_pix(3, 5, 2);
        expect_pix(3, 6, 2);
        done_pending++;
        send(1, 1, 3, 6, 2, 1'b0);
        wait_done("steep_line");

        // Reversed endpoints.
        expect_pix(0, 0, 7);
        expect_pix(1, 1, 7);
        expect_pix(2, 1, 7);
        expect_pix(3, 2, 7);
        expect_pix(4, 3, 7);
        done_pending++;
        send(4, 3, 0, 0, 7, 1'b0);
        wait_done("reversed_line");

        // Negative ystep, 2nd pixel stalled for 3 cycles.
        expect_pix(0, 3, 1);
        expect_pix(1, 2, 1);
        expect_pix(2, 1, 1);
        expect_pix(3, 0, 1);
        done_pending++;
        send(0, 3, 3, 0, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.i_pix_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stalled_pix_held", exp_q.size(), 3);
        bus.i_pix_ready = 1'b1;
        wait_done("backpressure_line");

        // Degenerate single-pixel line.
        expect_pix(5, 5, 3);
        done_pending++;
        send(5, 5, 5, 5, 3, 1'b0);
        wait_done("degenerate_line");

        // Abort during the 3rd pixel.
        expect_pix(0, 0, 6);
        expect_pix(1, 0, 6);
        send(0, 0, 9, 0, 6, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.i_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.i_abort = 1'b0;
        check("abort_busy", int'(bus.o_busy), 0);
        check("abort_pix_valid", int'(bus.o_pix_valid), 0);
        check("abort_cmd_ready", int'(bus.o_cmd_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_pix_consumed", exp_q.size(), 0);

        // Command after abort.
        expect_pix(0, 0, 2);
        expect_pix(1, 0, 2);
        expect_pix(2, 1, 2);
        done_pending++;
        send(2, 1, 0, 0, 2, 1'b0);
        wait_done("after_abort_line");

        // Reset mid-line drops the pixel at once.
        bus.i_pix_ready = 1'b0;
        send(0, 0, 9, 0, 4, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_pix_valid", int'(bus.o_pix_valid), 0);
        check("midrst_cmd_ready", int'(bus.o_cmd_ready), 1);
        check("midrst_pix_c", int'(bus.o_pix_color), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_idle", int'(bus.o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lda_engine.md
LDA_ENGINE -- requirements
Module: lda_engine

Interface
REQ-001 Parameter XW, default 9, x-coordinate width in bits.
REQ-002 Parameter YW, default 8, y-coordinate width in bits.
REQ-003 Parameter CW, default 3, pixel colour width in bits.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_cmd_valid  in  1  line command offered.
REQ-007 o_cmd_ready  out  1  engine idle and able to accept a command.
REQ-008 i_x0, i_x1  in  XW  endpoint x coordinates, unsigned.
REQ-009 i_y0, i_y1  in  YW  endpoint y coordinates, unsigned.
REQ-010 i_color  in  CW  colour attached to every pixel of the line.
REQ-011 i_abort  in  1  synchronous abort of the line in progress.
REQ-012 o_pix_valid  out  1  pixel output valid.
REQ-013 i_pix_ready  in  1  downstream accepts the pixel.
REQ-014 o_pix_x / o_pix_y / o_pix_color  out  XW / YW / CW  pixel to plot.
REQ-015 o_busy  out  1  high in every state except IDLE.
REQ-016 o_done  out  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, STEEP, ORDER, INIT, DRAW and DONE.
REQ-018 A command SHALL be accepted on an edge where i_cmd_valid and o_cmd_ready are both high; the engine registers the endpoints and colour, then enters STEEP.
REQ-019 o_cmd_ready SHALL be high only in IDLE.
REQ-020 STEEP: steep = |y1-y0| > |x1-x0| (strict); when steep, x/y SHALL be swapped for both endpoints; steep is held for the whole line; next state ORDER.
REQ-021 ORDER: when x0 > x1, the endpoints SHALL be exchanged, so pixel order may be the reverse of the input order; next state INIT.
REQ-022 INIT: dx = x1-x0, dy = |y1-y0|, ystep = +1 if y0 < y1 else -1, err = dx>>1, x = x0, y = y0; next state DRAW.
REQ-023 Internal coordinates SHALL be max(XW,YW) bits wide and err SHALL be signed, max(XW,YW)+2 bits, with no overflow for any input.
REQ-024 The first o_pix_valid SHALL appear in the 4th cycle after the accepting edge.
REQ-025 DRAW: o_pix_valid = 1, with the pixel equal to (x,y), or to (y,x) when steep, truncated to XW/YW bits.
REQ-026 A pixel handshake SHALL occur on an edge with o_pix_valid and i_pix_ready both high.
REQ-027 When a pixel handshake occurs and x == x1, the next state SHALL be DONE.
REQ-028 On any other pixel handshake: x+1; err' = err-dy; if err' < 0 then y += ystep and err' += dx.
REQ-029 While o_pix_valid=1 and i_pix_ready=0, all pixel outputs SHALL hold stable.
REQ-030 A line SHALL emit exactly max(|dx|,|dy|)+1 pixels; a degenerate line (x0=x1, y0=y1) emits exactly 1 pixel.
REQ-031 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-032 i_abort high in any non-IDLE state SHALL return the engine to IDLE on the next edge, with no o_done and no further pixels; i_abort is ignored in IDLE.
REQ-033 i_abort SHALL take priority over a simultaneous pixel handshake.
REQ-034 i_cmd_valid SHALL be ignored while busy.

Reset
REQ-035 While i_reset is high, the engine SHALL be in IDLE with o_cmd_ready=1 and o_pix_valid=0, o_busy=0, o_done=0.
REQ-036 While i_reset is high, o_pix_x, o_pix_y, o_pix_color and all internal registers SHALL be 0.
REQ-037 Reset asserted mid-line SHALL immediately drop o_pix_valid; the line is discarded.

Structure
REQ-038 The FSM state enum and the err width function SHALL live in shared package lda_pkg.
REQ-039 The datapath (swap, ordering, delta and error stepping) SHALL be one sub-module, lda_step, and the FSM SHALL stay in lda_engine.

Verification
REQ-040 Horizontal line: (0,0)->(4,0), ready held high -> pixels (0,0),(1,0),(2,0),(3,0),(4,0); o_done one cycle after the last pixel.
REQ-041 Steep line: (1,1)->(3,6) -> pixels (1,1),(1,2),(2,3),(2,4),(3,5),(3,6).
REQ-042 Reversed input: (4,3)->(0,0) -> pixels (0,0),(1,1),(2,1),(3,2),(4,3).
REQ-043 Negative ystep with backpressure: (0,3)->(3,0), i_pix_ready low for 3 cycles on the 2nd pixel -> pixels (0,3),(1,2),(2,1),(3,0); the 2nd pixel holds stable while stalled.
REQ-044 Degenerate line: (5,5)->(5,5) -> exactly one pixel (5,5), then o_done.
REQ-045 Abort: i_abort pulsed during the 3rd pixel of (0,0)->(9,0) -> IDLE next cycle, no o_done; a following command executes correctly.
